millis_timer_irq: RTL
=====================

Name: millis_timer_irq

Overview:
Memory-mapped timer peripheral that consumes the 32-bit millisecond count from the millisecond counter and exposes it to the RISC-V core. It provides a compare register with one-shot or periodic operation and raises a level interrupt when the count reaches the compare value. It sits between the millisecond counter and the core's data-bus decoder/interrupt input.

Parameters:
CMP_RESET, 32'hFFFF_FFFF, reset value of COMPARE.
PERIOD_RESET, 32'd1, reset value of PERIOD.

Ports:
clk_25_mhz  input  1  system clock, 25 MHz
rst  input  1  asynchronous reset, active-high; all state cleared on assertion, independent of clock
millis  input  32  millisecond count from the millisecond counter, same clock domain
sel  input  1  peripheral select from bus decoder; writes/reads valid only when 1
addr  input  4  byte offset; only addr[3:2] decoded; addr[1:0] ignored
we  input  1  write strobe, qualified by sel
wdata  input  32  write data
rdata  output  32  read data, combinational from addr and registered state; 0 when sel=0
irq  output  1  interrupt request, level, equals CTRL.PENDING

Behaviour:
- Register map (addr[3:2]):
  - 0 MILLIS: read-only; returns live millis input. Writes ignored.
  - 1 COMPARE: R/W, 32 bits.
  - 2 PERIOD: R/W, 32 bits.
  - 3 CTRL: bit0 EN (R/W), bit1 PERIODIC (R/W), bit2 PENDING (read; write-1-clears). Bits 31:3 read 0.
- Reset values:
  - COMPARE=CMP_RESET, PERIOD=PERIOD_RESET.
  - EN=0, PERIODIC=0, PENDING=0, irq=0.
  - millis_q=0.
- Tick detect:
  - millis_q registers millis every cycle.
  - tick = (millis != millis_q); one-cycle pulse per millisecond increment.
- Match:
  - match = EN & tick & (millis == COMPARE).
  - Equality only; a compare value already in the past never fires until the count wraps.
- On match, on the next clock edge:
  - PENDING<=1.
  - If PERIODIC=1: COMPARE <= COMPARE + PERIOD, modulo 2^32 (wrap allowed); EN stays 1.
  - If PERIODIC=0: EN<=0 (one-shot).
- irq timing: irq rises one clk_25_mhz cycle after the cycle in which millis first shows the compare value.
- Writes take effect on the clock edge where sel & we = 1.
- Simultaneous events:
  - Software write to COMPARE in a match cycle: written value wins; no periodic reload that cycle. PENDING is still set.
  - Software write to CTRL in a match cycle: written EN/PERIODIC values win over the one-shot EN clear.
  - W1C to PENDING in a match cycle: the set wins; PENDING=1.
- CTRL writes with bit2=0 leave PENDING unchanged. Setting EN does not clear PENDING.
- PERIOD=0 in periodic mode: COMPARE is unchanged; the block fires again only after the 2^32 ms wrap. Legal, no special handling.
- Reset of the millisecond counter (millis jumps to 0): counts as a tick if millis_q!=0. A match fires if COMPARE==0 and EN=1.
- Asynchronous rst mid-operation: all registers return to reset values immediately; irq drops without waiting for a clock.

Test Plan:
- Reset: assert rst asynchronously between clock edges -> irq=0 at once; reads return COMPARE=FFFF_FFFF, PERIOD=1, CTRL=0.
- One-shot: COMPARE=5, CTRL=1, millis steps 0..6 -> irq rises one cycle after millis=5; CTRL reads 4 (EN=0, PENDING=1); no further events. W1C CTRL=4 -> irq=0.
- Periodic: COMPARE=3, PERIOD=4, CTRL=3 -> PENDING set at millis 3, 7, 11 (cleared by W1C each time); COMPARE reads 7, 11, 15 after each event.
- Wrap: COMPARE=FFFF_FFFE, PERIOD=4, periodic, millis FFFF_FFFE -> FFFF_FFFF -> 0 -> 1 -> 2 -> fires at FFFF_FFFE, COMPARE becomes 2, fires again at millis=2.
- Collisions: W1C PENDING in the match cycle -> PENDING stays 1. COMPARE write of 20 in a periodic match cycle -> COMPARE reads 20, not the reloaded value.
- Holding millis constant at COMPARE for 25000 cycles -> exactly one match; MILLIS read returns live value; writes to offset 0 have no effect.

Source files
------------

// File: rtl/millis_timer_irq.sv
// Memory-mapped millisecond timer: exposes the live count, matches it against a
// one-shot or periodic COMPARE value and holds a level interrupt until W1C.
module millis_timer_irq #(
  parameter logic [31:0] CMP_RESET    = 32'hFFFF_FFFF,
  parameter logic [31:0] PERIOD_RESET = 32'd1
) (
  input  logic        clk_25_mhz,
  input  logic        rst,
  input  logic [31:0] millis,
  input  logic        sel,
  input  logic [3:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam logic [1:0] A_MILLIS  = 2'd0;
  localparam logic [1:0] A_COMPARE = 2'd1;
  localparam logic [1:0] A_PERIOD  = 2'd2;
  localparam logic [1:0] A_CTRL    = 2'd3;

  logic [31:0] millis_q;
  logic [31:0] compare;
  logic [31:0] period;
  logic        en;
  logic        periodic;
  logic        pending;

  logic        wr;
  logic [1:0]  reg_sel;
  logic        tick;
  logic        match;
  logic        unused_addr_lsbs;

  assign reg_sel          = addr[3:2];
  assign unused_addr_lsbs = ^addr[1:0];
  assign wr               = sel & we;
  assign tick             = (millis != millis_q);
  // Equality only: a compare value already passed waits for the 2^32 wrap.
  assign match            = en & tick & (millis == compare);

  always_ff @(posedge clk_25_mhz or posedge rst) begin
    if (rst) begin
      millis_q <= '0;
      compare  <= CMP_RESET;
      period   <= PERIOD_RESET;
      en       <= 1'b0;
      periodic <= 1'b0;
      pending  <= 1'b0;
    end else begin
      millis_q <= millis;

      // Software writes take priority over the automatic reload / one-shot clear.
      if (wr && reg_sel == A_COMPARE)
        compare <= wdata;
      else if (match && periodic)
        compare <= compare + period;

      if (wr && reg_sel == A_PERIOD)
        period <= wdata;

      if (wr && reg_sel == A_CTRL) begin
        en       <= wdata[0];
        periodic <= wdata[1];
      end else if (match && !periodic) begin
        en <= 1'b0;
      end

      // A match in the same cycle as W1C keeps the event visible.
      if (match)
        pending <= 1'b1;
      else if (wr && reg_sel == A_CTRL && wdata[2])
        pending <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (reg_sel)
        A_MILLIS:  rdata = millis;
        A_COMPARE: rdata = compare;
        A_PERIOD:  rdata = period;
        A_CTRL:    rdata = {29'd0, pending, periodic, en};
        default:   rdata = '0;
      endcase
    end
  end

  assign irq = pending;

endmodule
